// File: rtl/freq_gen_pkg.sv
// Shared types for the frequency-hopping NCO.
// Holds the hop FSM states, the OSR and LO-tap types, and the tap clamp helper.
package freq_gen_pkg;

   typedef logic [1:0] osr_level_t;
   typedef logic [2:0] lo_div_sel_t;

   localparam int LO_DIV_MAX = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOP_PEND
   } hop_state_t;

   function automatic lo_div_sel_t lo_tap(input lo_div_sel_t sel);
      return (sel > lo_div_sel_t'(LO_DIV_MAX)) ? lo_div_sel_t'(LO_DIV_MAX) : sel;
   endfunction

endpackage

// File: rtl/freq_tick_gen.sv
// Oversampling step strobe: one step every 2^(3-osr_level) clocks.
// The counter starts at 0 on clear; rate changes apply immediately without a counter reset.
module freq_tick_gen
   import freq_gen_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_i,
   input  logic       en_i,
   input  osr_level_t osr_level_i,
   output logic       step_o
);

   logic [2:0] cnt_q;
   logic [2:0] cnt_d;
   logic [2:0] mask;

   always_comb begin
      mask  = 3'b111 >> osr_level_i;
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 3'd1;
      end
   end

   assign step_o = en_i && ((cnt_q & mask) == 3'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/freq_hopper_nco.sv
// Phase-continuous multi-channel NCO with FSK deviation and hop-at-wrap channel changes.
// Hops are deferred to the first wrapping step so the phase never jumps.
module freq_hopper_nco
   import freq_gen_pkg::*;
#(
   parameter  int ACC_W  = 30,
   parameter  int NUM_CH = 8,
   parameter  int DEV_W  = 16,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_addr,
   input  logic [ACC_W-1:0]  cfg_data,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              ch_sel_valid,
   output logic              ch_sel_ready,
   input  logic              fsk_bit,
   input  logic [DEV_W-1:0]  fsk_dev,
   input  osr_level_t        osr_level,
   input  lo_div_sel_t       lo_div_sel,
   output logic              running,
   output logic              lo_out,
   output logic [ACC_W-1:0]  phase,
   output logic [CH_W-1:0]   active_ch,
   output logic              hop_done
);

   hop_state_t        state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  f_cur_q, f_cur_d;
   logic [ACC_W-1:0]  ch_tab_q [NUM_CH];
   logic [CH_W-1:0]   active_ch_q, active_ch_d;
   logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
   logic              hop_done_q, hop_done_d;
   logic              lo_q, lo_d;
   logic [ACC_W-1:0]  lo_shift;
   logic [ACC_W-1:0]  dev_ext;
   logic [ACC_W-1:0]  f_eff;
   logic [ACC_W:0]    sum;
   logic              step;
   logic              wrap;
   logic              go;
   logic              hs;

   assign go           = (state_q == IDLE) && start && !stop;
   assign ch_sel_ready = (state_q != HOP_PEND);
   assign hs           = ch_sel_valid && ch_sel_ready;

   freq_tick_gen u_tick (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (go),
      .en_i        (state_q != IDLE),
      .osr_level_i (osr_level),
      .step_o      (step)
   );

   assign dev_ext = ACC_W'(fsk_dev);
   assign f_eff   = fsk_bit ? (f_cur_q + dev_ext) : (f_cur_q - dev_ext);
   assign sum     = {1'b0, acc_q} + {1'b0, f_eff};
   assign wrap    = sum[ACC_W];

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      f_cur_d     = f_cur_q;
      active_ch_d = active_ch_q;
      pend_ch_d   = pend_ch_q;
      hop_done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               active_ch_d = ch_sel;
               hop_done_d  = 1'b1;
            end
            if (go) begin
               state_d = RUN;
               acc_d   = '0;
               f_cur_d = ch_tab_q[active_ch_d];
            end
         end
         RUN, HOP_PEND: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               if (step) begin
                  acc_d = sum[ACC_W-1:0];
               end
               // The wrapping step itself still advances with the old carrier.
               if (state_q == HOP_PEND) begin
                  if (step && wrap) begin
                     f_cur_d     = ch_tab_q[pend_ch_q];
                     active_ch_d = pend_ch_q;
                     hop_done_d  = 1'b1;
                     state_d     = RUN;
                  end
               end else if (hs) begin
                  pend_ch_d = ch_sel;
                  state_d   = HOP_PEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      lo_shift = acc_d << lo_tap(lo_div_sel);
      lo_d     = lo_shift[ACC_W-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         f_cur_q     <= '0;
         active_ch_q <= '0;
         pend_ch_q   <= '0;
         hop_done_q  <= 1'b0;
         lo_q        <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_tab_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         f_cur_q     <= f_cur_d;
         active_ch_q <= active_ch_d;
         pend_ch_q   <= pend_ch_d;
         hop_done_q  <= hop_done_d;
         lo_q        <= lo_d;
         if (cfg_we) begin
            ch_tab_q[cfg_addr] <= cfg_data;
         end
      end
   end

   assign running   = (state_q != IDLE);
   assign phase     = acc_q;
   assign active_ch = active_ch_q;
   assign hop_done  = hop_done_q;
   assign lo_out    = lo_q;

endmodule

// File: tb/tb_freq_hopper_nco.sv
// Scoreboard bench for freq_hopper_nco: a cycle-level reference model queues expected
// outputs at each clock edge and a monitor pops and compares them on the falling edge.
module tb_freq_hopper_nco;

   localparam int     ACC_W  = 30;
   localparam int     NUM_CH = 8;
   localparam int     DEV_W  = 16;
   localparam int     CH_W   = 3;
   localparam longint MOD    = 64'd1 << ACC_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stop;
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_addr;
   logic [ACC_W-1:0]  cfg_data;
   logic [CH_W-1:0]   ch_sel;
   logic              ch_sel_valid;
   logic              ch_sel_ready;
   logic              fsk_bit;
   logic [DEV_W-1:0]  fsk_dev;
   logic [1:0]        osr_level;
   logic [2:0]        lo_div_sel;
   logic              running;
   logic              lo_out;
   logic [ACC_W-1:0]  phase;
   logic [CH_W-1:0]   active_ch;
   logic              hop_done;

   always #5 clk = ~clk;

   freq_hopper_nco #(.ACC_W(ACC_W), .NUM_CH(NUM_CH), .DEV_W(DEV_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .ch_sel       (ch_sel),
      .ch_sel_valid (ch_sel_valid),
      .ch_sel_ready (ch_sel_ready),
      .fsk_bit      (fsk_bit),
      .fsk_dev      (fsk_dev),
      .osr_level    (osr_level),
      .lo_div_sel   (lo_div_sel),
      .running      (running),
      .lo_out       (lo_out),
      .phase        (phase),
      .active_ch    (active_ch),
      .hop_done     (hop_done)
   );

   typedef struct {
      bit     run;
      bit     lo;
      longint ph;
      int     ch;
      bit     hd;
      bit     rdy;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: plain integer arithmetic on phase and carrier.
   longint m_tab [NUM_CH];
   longint m_ph, m_f;
   int     m_ch, m_pch, m_n;
   bit     m_run, m_pend, m_hd;

   always @(posedge clk) begin : ref_model
      exp_t   e;
      longint fe, s;
      int     per, tap;
      bit     was_pend;
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) m_tab[i] = 0;
         m_ph = 0; m_f = 0; m_ch = 0; m_pch = 0; m_n = 0;
         m_run = 0; m_pend = 0; m_hd = 0;
      end else begin
         m_hd = 0;
         if (!m_run) begin
            if (ch_sel_valid) begin
               m_ch = ch_sel;
               m_hd = 1;
            end
            if (start && !stop) begin
               m_run = 1;
               m_ph  = 0;
               m_f   = m_tab[m_ch];
               m_n   = 0;
            end
         end else if (stop) begin
            m_run  = 0;
            m_pend = 0;
         end else begin
            was_pend = m_pend;
            per = 1 << (3 - osr_level);
            if ((m_n % per) == 0) begin
               fe = fsk_bit ? (m_f + fsk_dev) : (m_f - fsk_dev + MOD);
               fe = fe % MOD;
               s  = m_ph + fe;
               m_ph = s % MOD;
               if (was_pend && s >= MOD) begin
                  m_f    = m_tab[m_pch];
                  m_ch   = m_pch;
                  m_pend = 0;
                  m_hd   = 1;
               end
            end
            m_n++;
            if (!was_pend && ch_sel_valid) begin
               m_pend = 1;
               m_pch  = ch_sel;
            end
         end
         if (cfg_we) m_tab[cfg_addr] = cfg_data;
      end
      tap   = (lo_div_sel > 4) ? 4 : int'(lo_div_sel);
      e.run = m_run;
      e.lo  = ((m_ph >> (ACC_W - 1 - tap)) & 1) != 0;
      e.ph  = m_ph;
      e.ch  = m_ch;
      e.hd  = m_hd;
      e.rdy = !m_pend;
      sb_q.push_back(e);
   end

   task automatic check(input string name, input longint act, input longint want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("running",      longint'(running),      longint'(e.run));
         check("lo_out",       longint'(lo_out),       longint'(e.lo));
         check("phase",        longint'(phase),        e.ph);
         check("active_ch",    longint'(active_ch),    longint'(e.ch));
         check("hop_done",     longint'(hop_done),     longint'(e.hd));
         check("ch_sel_ready", longint'(ch_sel_ready), longint'(e.rdy));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [ACC_W-1:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a[CH_W-1:0];
      cfg_data = d;
      cyc(1);
      cfg_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic request(input int c);
      ch_sel       = c[CH_W-1:0];
      ch_sel_valid = 1'b1;
      cyc(1);
      ch_sel_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      ch_sel = '0; ch_sel_valid = 1'b0;
      fsk_bit = 1'b0; fsk_dev = '0; osr_level = 2'd3; lo_div_sel = 3'd0;
      cyc(3);
      reset = 1'b0;
      wr(0, 30'h0400_0000);
      wr(1, 30'h0800_0000);
      for (int i = 2; i < NUM_CH; i++) wr(i, ACC_W'($urandom));

      // Basic rate, then oversampling rates and tap selection.
      pulse_start();
      cyc(40);
      osr_level = 2'd1;
      cyc(70);
      lo_div_sel = 3'd2;
      cyc(40);
      lo_div_sel = 3'd6;
      cyc(20);
      lo_div_sel = 3'd0;
      osr_level  = 2'd3;

      // FSK deviation around the carrier.
      fsk_dev = 16'h0100;
      for (int i = 0; i < 30; i++) begin
         fsk_bit = 1'($urandom);
         cyc(1);
      end
      fsk_dev = '0;

      // Restart and hop to channel 1 on clock 3; a second request while pending is ignored.
      stop = 1'b1; cyc(1); stop = 1'b0;
      pulse_start();
      cyc(2);
      request(1);
      ch_sel = 3'd2; ch_sel_valid = 1'b1;
      cyc(4);
      ch_sel_valid = 1'b0;
      cyc(30);

      // Stop while a hop is pending, then start and stop together in IDLE.
      request(0);
      cyc(3);
      stop = 1'b1; cyc(1); stop = 1'b0;
      cyc(10);
      start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
      cyc(5);

      // Table write to the active channel while running.
      pulse_start();
      cyc(3);
      wr(1, 30'h0123_4567);
      cyc(20);

      // Reset with a hop pending, then restart from the cleared table.
      request(3);
      cyc(2);
      reset = 1'b1; cyc(1); reset = 1'b0;
      cyc(2);
      pulse_start();
      cyc(20);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         start        = ($urandom_range(0, 19) == 0);
         stop         = ($urandom_range(0, 59) == 0);
         ch_sel_valid = !start && ($urandom_range(0, 9) == 0);
         ch_sel       = CH_W'($urandom);
         cfg_we       = ($urandom_range(0, 14) == 0);
         cfg_addr     = CH_W'($urandom);
         cfg_data     = ACC_W'($urandom) >> $urandom_range(0, 5);
         fsk_bit      = 1'($urandom);
         if ($urandom_range(0, 29) == 0) fsk_dev = DEV_W'($urandom);
         if ($urandom_range(0, 39) == 0) osr_level = 2'($urandom);
         if ($urandom_range(0, 39) == 0) lo_div_sel = 3'($urandom);
         cyc(1);
      end
      start = 1'b0; stop = 1'b0; ch_sel_valid = 1'b0; cfg_we = 1'b0;
      cyc(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
